wb_trace_checker: RTL and testbench

- Sits beside the multi-cycle CPU top and consumes its debug writeback port: debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_addr and debug_wb_rf_wdata.
- Each register-file write is buffered and compared in order against a golden trace held in a synchronous-read trace ROM.
- Reports pass/fail, event and error counts, and the first mismatching entry, for simulation and on-board self-check.

---
 rtl/wb_trace_checker.sv | 217 +++++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_checker
//  Purpose  : Compares the CPU debug writeback stream, in order, against a
//             golden trace held in a synchronous-read ROM. Reports pass/fail,
//             event/error counts and the first mismatching entry.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_trace_checker #(
  parameter int TRACE_AW    = 12,
  parameter int TRACE_LEN   = 1024,
  parameter int FIFO_AW     = 2,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                chk_en,
  input  logic [31:0]         debug_wb_pc,
  input  logic                debug_wb_rf_wen,
  input  logic [4:0]          debug_wb_rf_addr,
  input  logic [31:0]         debug_wb_rf_wdata,
  output logic [TRACE_AW-1:0] trace_addr,
  input  logic [68:0]         trace_data,
  output logic                done,
  output logic                pass,
  output logic                error,
  output logic [3:0]          err_kind,
  output logic [TRACE_AW:0]   event_count,
  output logic [15:0]         err_count,
  output logic [31:0]         exp_pc,
  output logic [31:0]         got_pc,
  output logic [31:0]         exp_wdata,
  output logic [31:0]         got_wdata
);

  localparam int                c_depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  c_full  = (FIFO_AW+1)'(c_depth);
  localparam logic [TRACE_AW:0] c_len   = (TRACE_AW+1)'(TRACE_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_PASS  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Event FIFO: storage plus read/write pointers and occupancy count.
  logic [68:0]        fifo_mem_q [c_depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  // Checker bookkeeping.
  logic [TRACE_AW:0]   idx_q, idx_d;
  logic [TRACE_AW-1:0] taddr_q, taddr_d;
  logic                error_q, error_d;
  logic [3:0]          kind_q, kind_d;
  logic [15:0]         errcnt_q, errcnt_d;
  logic [31:0]         exp_pc_q, exp_pc_d, got_pc_q, got_pc_d;
  logic [31:0]         exp_wd_q, exp_wd_d, got_wd_q, got_wd_d;

  logic        w_event, w_push, w_pop, w_full, w_empty, w_ovf;
  logic [68:0] w_head;
  logic [31:0] w_head_pc, w_head_data, w_gold_pc, w_gold_data;
  logic [4:0]  w_head_addr, w_gold_addr;
  logic        w_pc_mis, w_ad_mis, w_mis;

  // Once failed, the debug port is ignored so no further overflow is flagged.
  assign w_event = chk_en && debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0)
                   && (state_q != S_FAIL);
  assign w_pop   = (state_q == S_CMP);
  // Full is judged after a same-cycle pop, so push+pop at full is legal.
  assign w_full  = (cnt_q == c_full);
  assign w_empty = (cnt_q == '0);
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_ovf   = w_event && w_full && !w_pop;

  assign w_head      = fifo_mem_q[rptr_q];
  assign w_head_pc   = w_head[68:37];
  assign w_head_addr = w_head[36:32];
  assign w_head_data = w_head[31:0];
  assign w_gold_pc   = trace_data[68:37];
  assign w_gold_addr = trace_data[36:32];
  assign w_gold_data = trace_data[31:0];
  assign w_pc_mis    = (w_head_pc != w_gold_pc);
  assign w_ad_mis    = (w_head_addr != w_gold_addr) || (w_head_data != w_gold_data);
  assign w_mis       = w_pc_mis || w_ad_mis;

  always_comb begin
    cnt_d = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wptr_q] <= {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (w_pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Next-state and result-register logic for the compare sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    taddr_d  = taddr_q;
    error_d  = error_q;
    kind_d   = kind_q;
    errcnt_d = errcnt_q;
    exp_pc_d = exp_pc_q;
    got_pc_d = got_pc_q;
    exp_wd_d = exp_wd_q;
    got_wd_d = got_wd_q;
    case (state_q)
      S_IDLE: begin
        if ((idx_q == c_len) && w_empty) state_d = S_PASS;
        else if (!w_empty)               state_d = S_FETCH;
      end
      S_FETCH: begin
        if (idx_q == c_len) begin
          // More writes than golden entries.
          error_d   = 1'b1;
          kind_d[2] = 1'b1;
          state_d   = S_FAIL;
        end else begin
          taddr_d = idx_q[TRACE_AW-1:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_CMP;
      S_CMP: begin
        idx_d   = idx_q + (TRACE_AW+1)'(1);
        state_d = S_IDLE;
        if (w_mis) begin
          if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
          if (!error_q) begin
            error_d  = 1'b1;
            kind_d   = {2'b00, w_ad_mis, w_pc_mis};
            exp_pc_d = w_gold_pc;
            got_pc_d = w_head_pc;
            exp_wd_d = w_gold_data;
            got_wd_d = w_head_data;
          end
          if (STOP_ON_ERR) state_d = S_FAIL;
        end
      end
      // A late write after completion is still checked (and flagged extra).
      S_PASS: if (!w_empty) state_d = S_FETCH;
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
    // Overflow is fatal regardless of STOP_ON_ERR.
    if (w_ovf) begin
      error_d   = 1'b1;
      kind_d[3] = 1'b1;
      state_d   = S_FAIL;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      taddr_q  <= '0;
      error_q  <= 1'b0;
      kind_q   <= '0;
      errcnt_q <= '0;
      exp_pc_q <= '0;
      got_pc_q <= '0;
      exp_wd_q <= '0;
      got_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      taddr_q  <= taddr_d;
      error_q  <= error_d;
      kind_q   <= kind_d;
      errcnt_q <= errcnt_d;
      exp_pc_q <= exp_pc_d;
      got_pc_q <= got_pc_d;
      exp_wd_q <= exp_wd_d;
      got_wd_q <= got_wd_d;
    end
  end

  assign trace_addr  = taddr_q;
  assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass        = (state_q == S_PASS) && !error_q;
  assign error       = error_q;
  assign err_kind    = kind_q;
  assign event_count = idx_q;
  assign err_count   = errcnt_q;
  assign exp_pc      = exp_pc_q;
  assign got_pc      = got_pc_q;
  assign exp_wdata   = exp_wd_q;
  assign got_wdata   = got_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_trace_checker
//  Purpose  : Self-checking bench for wb_trace_checker. Two instances share
//             the debug port: one stops on first error, one keeps counting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_trace_checker;

  localparam int AW  = 4;
  localparam int LEN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        chk_en, wen;
  logic [4:0]  addr;
  logic [31:0] pc, wdata;

  logic [AW-1:0] s_taddr, n_taddr;
  logic [68:0]   s_tdata, n_tdata;
  logic          s_done, s_pass, s_error, n_done, n_pass, n_error;
  logic [3:0]    s_kind, n_kind;
  logic [AW:0]   s_ec, n_ec;
  logic [15:0]   s_errc, n_errc;
  logic [31:0]   s_exp_pc, s_got_pc, s_exp_wd, s_got_wd;
  logic [31:0]   n_exp_pc, n_got_pc, n_exp_wd, n_got_wd;

  logic [68:0] rom [0:15];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic        counted;  // compared by the keep-going instance
    logic        mism;     // compare is expected to mismatch
  } vec_t;

  typedef struct {
    int ec;
    int errc;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   model_ec, model_errc;
  logic [AW:0] prev_ec = '0;

  always #5 clk = ~clk;

  wb_trace_checker #(.TRACE_AW(AW), .TRACE_LEN(LEN), .FIFO_AW(2), .STOP_ON_ERR(1'b1)) dut_s (
    .clk(clk), .rst(rst), .chk_en(chk_en), .debug_wb_pc(pc), .debug_wb_rf_wen(wen),
    .debug_wb_rf_addr(addr), .debug_wb_rf_wdata(wdata), .trace_addr(s_taddr),
    .trace_data(s_tdata), .done(s_done), .pass(s_pass), .error(s_error),
    .err_kind(s_kind), .event_count(s_ec), .err_count(s_errc), .exp_pc(s_exp_pc),
    .got_pc(s_got_pc), .exp_wdata(s_exp_wd), .got_wdata(s_got_wd));

  wb_trace_checker #(.TRACE_AW(AW), .TRACE_LEN(LEN), .FIFO_AW(2), .STOP_ON_ERR(1'b0)) dut_n (
    .clk(clk), .rst(rst), .chk_en(chk_en), .debug_wb_pc(pc), .debug_wb_rf_wen(wen),
    .debug_wb_rf_addr(addr), .debug_wb_rf_wdata(wdata), .trace_addr(n_taddr),
    .trace_data(n_tdata), .done(n_done), .pass(n_pass), .error(n_error),
    .err_kind(n_kind), .event_count(n_ec), .err_count(n_errc), .exp_pc(n_exp_pc),
    .got_pc(n_got_pc), .exp_wdata(n_exp_wd), .got_wdata(n_got_wd));

  // Synchronous-read golden ROM, one read port per instance.
  always @(posedge clk) begin
    s_tdata <= rom[s_taddr];
    n_tdata <= rom[n_taddr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: each time the keep-going instance retires a compare, pop.
  always @(negedge clk) begin
    if (!rst) prev_ec = '0;
    else if (n_ec != prev_ec) begin
      prev_ec = n_ec;
      if (n_ec != '0) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'(n_ec), 32'd0);
        else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_event_count", 32'(n_ec), 32'(e.ec));
          chk("sb_err_count", 32'(n_errc), 32'(e.errc));
        end
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d,
                              input logic c, input logic cnt, input logic m);
    vec_t v;
    v.pc = p; v.addr = a; v.data = d; v.chk = c; v.counted = cnt; v.mism = m;
    return v;
  endfunction

  task automatic set_gold(input int i, input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
    rom[i] = {p, a, d};
  endtask

  task automatic good_gold();
    for (int i = 0; i < 16; i++) rom[i] = '0;
    set_gold(0, 32'h0, 5'd1, 32'h5);
    set_gold(1, 32'h4, 5'd2, 32'hA);
    set_gold(2, 32'h8, 5'd3, 32'hF);
  endtask

  task automatic do_reset();
    rst = 1'b0; chk_en = 1'b0; wen = 1'b0; addr = '0; pc = '0; wdata = '0;
    sbq.delete(); tbl.delete();
    model_ec = 0; model_errc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1; chk_en = 1'b1;
    @(negedge clk);
  endtask

  // One single-cycle write followed by three quiet cycles (CPU pacing).
  task automatic drive_ev(input vec_t v);
    @(negedge clk);
    chk_en = v.chk; wen = 1'b1; addr = v.addr; pc = v.pc; wdata = v.data;
    @(negedge clk);
    chk_en = 1'b1; wen = 1'b0; addr = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_table();
    foreach (tbl[i]) begin
      if (tbl[i].counted) begin
        model_ec++;
        if (tbl[i].mism) model_errc++;
        sbq.push_back('{model_ec, model_errc});
      end
      drive_ev(tbl[i]);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(s_done && n_done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_timeout: done s=%0b n=%0b, required both 1 within 60 cycles", name, s_done, n_done);
    end
  endtask

  task automatic chk_both_final(input string name, input logic pass_e, input logic [3:0] kind_e,
                                input int s_ec_e, input int n_ec_e);
    chk({name, "_s_done"}, 32'(s_done), 32'd1);
    chk({name, "_n_done"}, 32'(n_done), 32'd1);
    chk({name, "_s_pass"}, 32'(s_pass), 32'(pass_e));
    chk({name, "_n_pass"}, 32'(n_pass), 32'(pass_e));
    chk({name, "_s_kind"}, 32'(s_kind), 32'(kind_e));
    chk({name, "_s_ec"},   32'(s_ec), 32'(s_ec_e));
    chk({name, "_n_ec"},   32'(n_ec), 32'(n_ec_e));
    chk({name, "_sb_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    good_gold();
    do_reset();

    // Reset state.
    chk("rst_done",  32'(s_done), 32'd0);
    chk("rst_pass",  32'(s_pass), 32'd0);
    chk("rst_error", 32'(n_error), 32'd0);
    chk("rst_kind",  32'(n_kind), 32'd0);
    chk("rst_ec",    32'(n_ec), 32'd0);
    chk("rst_errc",  32'(n_errc), 32'd0);
    chk("rst_taddr", 32'(s_taddr), 32'd0);

    // Three matching writes.
    tbl.push_back(mk(32'h0, 5'd1, 32'h5, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h4, 5'd2, 32'hA, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h8, 5'd3, 32'hF, 1'b1, 1'b1, 1'b0));
    apply_table();
    wait_done("match");
    chk_both_final("match", 1'b1, 4'b0000, 3, 3);
    chk("match_s_errc", 32'(s_errc), 32'd0);
    chk("match_n_errc", 32'(n_errc), 32'd0);

    // Data error on event 2, pc error on event 3.
    do_reset();
    tbl.push_back(mk(32'h0, 5'd1, 32'h5, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h4, 5'd2, 32'hB, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(32'hC, 5'd3, 32'hF, 1'b1, 1'b1, 1'b1));
    apply_table();
    wait_done("mism");
    chk_both_final("mism", 1'b0, 4'b0010, 2, 3);
    chk("mism_s_error",  32'(s_error), 32'd1);
    chk("mism_s_exp_wd", s_exp_wd, 32'hA);
    chk("mism_s_got_wd", s_got_wd, 32'hB);
    chk("mism_s_got_pc", s_got_pc, 32'h4);
    chk("mism_s_exp_pc", s_exp_pc, 32'h4);
    chk("mism_s_errc",   32'(s_errc), 32'd1);
    chk("mism_n_errc",   32'(n_errc), 32'd2);
    chk("mism_n_kind",   32'(n_kind), 32'b0010);
    chk("mism_n_got_wd", n_got_wd, 32'hB);
    chk("mism_n_got_pc", n_got_pc, 32'h4);

    // r0 writes and chk_en=0 writes are not events.
    do_reset();
    tbl.push_back(mk(32'h0,  5'd1, 32'h5,  1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h40, 5'd0, 32'h77, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(32'h4,  5'd2, 32'hA,  1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h44, 5'd5, 32'h99, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h8,  5'd3, 32'hF,  1'b1, 1'b1, 1'b0));
    apply_table();
    wait_done("filter");
    chk_both_final("filter", 1'b1, 4'b0000, 3, 3);
    chk("filter_n_errc", 32'(n_errc), 32'd0);

    // rf_wen held for six cycles overflows the four-entry FIFO.
    do_reset();
    model_ec = 1;
    sbq.push_back('{1, 0});
    @(negedge clk);
    chk_en = 1'b1; wen = 1'b1; addr = 5'd1; pc = 32'h0; wdata = 32'h5;
    repeat (6) @(negedge clk);
    wen = 1'b0; addr = '0;
    wait_done("ovf");
    chk_both_final("ovf", 1'b0, 4'b1000, 1, 1);
    chk("ovf_n_kind",  32'(n_kind), 32'b1000);
    chk("ovf_s_error", 32'(s_error), 32'd1);

    // A fourth write beyond the golden length.
    do_reset();
    tbl.push_back(mk(32'h0, 5'd1, 32'h5,  1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h4, 5'd2, 32'hA,  1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h8, 5'd3, 32'hF,  1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'hC, 5'd4, 32'h14, 1'b1, 1'b0, 1'b0));
    apply_table();
    wait_done("extra");
    chk_both_final("extra", 1'b0, 4'b0100, 3, 3);
    chk("extra_n_kind", 32'(n_kind), 32'b0100);
    chk("extra_n_errc", 32'(n_errc), 32'd0);

    // Asynchronous reset in the middle of the second compare.
    do_reset();
    tbl.push_back(mk(32'h0, 5'd1, 32'h5, 1'b1, 1'b1, 1'b0));
    apply_table();
    drive_ev(mk(32'h4, 5'd2, 32'hA, 1'b1, 1'b0, 1'b0));
    chk("pre_rst_ec",    32'(n_ec), 32'd1);
    chk("pre_rst_taddr", 32'(n_taddr), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ec",    32'(n_ec), 32'd0);
    chk("arst_taddr", 32'(n_taddr), 32'd0);
    chk("arst_error", 32'(n_error), 32'd0);
    chk("arst_s_ec",  32'(s_ec), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_fifo_empty_ec", 32'(n_ec), 32'd0);
    chk("post_rst_done",          32'(n_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
